// File: rtl/burst_accumulator.sv
// Sums up to BURST_LEN unsigned beats (or fewer, closed by i_last) and presents total + beat count.
// Latency: o_req rises the cycle after the closing beat; i_ack returns the cycle after the result handshake.
// Backpressure: results hold in HOLD until o_ack; upstream sees i_ack low for the whole HOLD state.
module burst_accumulator #(
    parameter int  DATA_W    = 32,
    parameter int  BURST_LEN = 4,
    localparam int ACC_W     = DATA_W + $clog2(BURST_LEN),
    localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic              i_ack,
    output logic              o_req,
    output logic [ACC_W-1:0]  o_sum,
    output logic [CNT_W-1:0]  o_beats,
    input  logic              o_ack
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] cnt_inc;

    assign in_xfer  = i_req & i_ack;
    assign out_xfer = o_req & o_ack;
    assign cnt_inc  = o_beats + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // A burst closes on its last permitted beat or on i_last, whichever comes first.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: begin
                if (in_xfer && (cnt_inc == CNT_W'(BURST_LEN) || i_last)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_xfer) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Handshake outputs depend on state alone, so neither side sees a combinational path.
    always_comb begin
        i_ack = 1'b0;
        o_req = 1'b0;
        case (state)
            ACCUM:   i_ack = 1'b1;
            HOLD:    o_req = 1'b1;
            default: i_ack = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_sum   <= '0;
            o_beats <= '0;
        end else if (in_xfer) begin
            o_sum   <= o_sum + ACC_W'(i_data);
            o_beats <= cnt_inc;
        end else if (out_xfer) begin
            o_sum   <= '0;
            o_beats <= '0;
        end
    end

endmodule

// File: tb/tb_burst_accumulator.sv
module tb_burst_accumulator;

    localparam int DATA_W = 32;
    localparam int BLEN   = 4;
    localparam int ACC_W  = DATA_W + $clog2(BLEN);
    localparam int CNT_W  = $clog2(BLEN + 1);

    logic              clk = 1'b0;
    logic              rst, i_req, i_last, o_ack, i_ack, o_req;
    logic [DATA_W-1:0] i_data;
    logic [ACC_W-1:0]  o_sum;
    logic [CNT_W-1:0]  o_beats;

    logic              rst1, i_req1, i_last1, o_ack1, i_ack1, o_req1;
    logic [DATA_W-1:0] i_data1;
    logic [DATA_W-1:0] o_sum1;
    logic [0:0]        o_beats1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    burst_accumulator #(.DATA_W(DATA_W), .BURST_LEN(BLEN)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_data(i_data), .i_last(i_last),
        .i_ack(i_ack), .o_req(o_req), .o_sum(o_sum), .o_beats(o_beats), .o_ack(o_ack)
    );

    burst_accumulator #(.DATA_W(DATA_W), .BURST_LEN(1)) dut1 (
        .clk(clk), .rst(rst1), .i_req(i_req1), .i_data(i_data1), .i_last(i_last1),
        .i_ack(i_ack1), .o_req(o_req1), .o_sum(o_sum1), .o_beats(o_beats1), .o_ack(o_ack1)
    );

    typedef struct {
        logic              rst, req, last, oack;
        logic [DATA_W-1:0] data;
        logic              exp_iack, exp_oreq;
        logic [ACC_W-1:0]  exp_sum;
        logic [CNT_W-1:0]  exp_beats;
    } vec_t;

    vec_t tbl[80];
    int   n_vec = 0;

    task automatic add(input logic r, input logic rq, input logic [DATA_W-1:0] d, input logic l,
                       input logic oa, input logic eia, input logic eor,
                       input logic [ACC_W-1:0] es, input logic [CNT_W-1:0] eb);
        tbl[n_vec].rst = r;   tbl[n_vec].req = rq;  tbl[n_vec].data = d;
        tbl[n_vec].last = l;  tbl[n_vec].oack = oa;
        tbl[n_vec].exp_iack = eia; tbl[n_vec].exp_oreq = eor;
        tbl[n_vec].exp_sum = es;   tbl[n_vec].exp_beats = eb;
        n_vec++;
    endtask

    // Beat in ACCUM (stays accumulating) / beat that closes / idle cycle helpers.
    task automatic beat(input logic [DATA_W-1:0] d, input logic l, input logic [ACC_W-1:0] es,
                        input logic [CNT_W-1:0] eb, input logic closes);
        add(0, 1, d, l, 0, !closes, closes, es, eb);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {iack,oreq,sum,beats}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack4(logic ia, logic orq, logic [ACC_W-1:0] s, logic [CNT_W-1:0] b);
        return 64'({ia, orq, s, b});
    endfunction

    function automatic logic [63:0] pack1(logic ia, logic orq, logic [DATA_W-1:0] s, logic b);
        return 64'({ia, orq, s, b});
    endfunction

    initial begin
        // ---------------- directed table ----------------
        add(1, 0, 0, 0, 0, 1, 0, 0, 0);
        beat(1, 0, 1, 1, 0); beat(2, 0, 3, 2, 0); beat(3, 0, 6, 3, 0); beat(4, 0, 10, 4, 1);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0);
        beat(32'hFFFF_FFFF, 0, 34'h0_FFFF_FFFF, 1, 0);
        beat(32'hFFFF_FFFF, 0, 34'h1_FFFF_FFFE, 2, 0);
        beat(32'hFFFF_FFFF, 0, 34'h2_FFFF_FFFD, 3, 0);
        beat(32'hFFFF_FFFF, 0, 34'h3_FFFF_FFFC, 4, 1);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0);
        beat(7, 0, 7, 1, 0); beat(5, 1, 12, 2, 1);
        add(0, 0, 0, 0, 0, 0, 1, 12, 2);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0);
        beat(1, 0, 1, 1, 0); beat(1, 0, 2, 2, 0); beat(1, 0, 3, 3, 0); beat(1, 0, 4, 4, 1);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0);
        beat(2, 0, 2, 1, 0); beat(2, 0, 4, 2, 0); beat(2, 0, 6, 3, 0); beat(2, 0, 8, 4, 1);
        for (int i = 0; i < 6; i++) add(0, 1, 9, 0, 0, 0, 1, 8, 4);
        add(0, 1, 9, 0, 1, 1, 0, 0, 0);
        beat(9, 0, 9, 1, 0); beat(0, 1, 9, 2, 1);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0);
        beat(3, 0, 3, 1, 0);
        add(0, 0, 77, 0, 0, 1, 0, 3, 1); add(0, 0, 77, 1, 0, 1, 0, 3, 1);
        beat(4, 0, 7, 2, 0);
        add(0, 0, 0, 0, 0, 1, 0, 7, 2);
        beat(5, 0, 12, 3, 0); beat(6, 0, 18, 4, 1);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0);
        beat(10, 0, 10, 1, 0); beat(20, 0, 30, 2, 0);
        add(1, 1, 99, 0, 0, 1, 0, 0, 0);
        beat(1, 0, 1, 1, 0); beat(2, 0, 3, 2, 0); beat(3, 0, 6, 3, 0); beat(4, 0, 10, 4, 1);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0);
        beat(1, 0, 1, 1, 0); beat(1, 0, 2, 2, 0); beat(1, 0, 3, 3, 0); beat(1, 1, 4, 4, 1);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0);
        beat(5, 0, 5, 1, 0); beat(0, 1, 5, 2, 1);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0);

        rst1 = 1; i_req1 = 0; i_data1 = 0; i_last1 = 0; o_ack1 = 0;
        for (int i = 0; i < n_vec; i++) begin
            rst = tbl[i].rst; i_req = tbl[i].req; i_data = tbl[i].data;
            i_last = tbl[i].last; o_ack = tbl[i].oack;
            tick();
            check($sformatf("vec%0d", i), pack4(i_ack, o_req, o_sum, o_beats),
                  pack4(tbl[i].exp_iack, tbl[i].exp_oreq, tbl[i].exp_sum, tbl[i].exp_beats));
        end

        // ---------------- BURST_LEN=1 corner ----------------
        rst1 = 1; tick();
        check("len1_reset", pack1(i_ack1, o_req1, o_sum1, o_beats1), pack1(1, 0, 0, 0));
        rst1 = 0; i_req1 = 1; i_data1 = 32'hDEAD_BEEF; tick();
        check("len1_beat", pack1(i_ack1, o_req1, o_sum1, o_beats1), pack1(0, 1, 32'hDEAD_BEEF, 1));
        i_data1 = 32'h1234_5678; tick();
        check("len1_hold", pack1(i_ack1, o_req1, o_sum1, o_beats1), pack1(0, 1, 32'hDEAD_BEEF, 1));
        o_ack1 = 1; tick();
        check("len1_release", pack1(i_ack1, o_req1, o_sum1, o_beats1), pack1(1, 0, 0, 0));
        o_ack1 = 0; tick();
        check("len1_next", pack1(i_ack1, o_req1, o_sum1, o_beats1), pack1(0, 1, 32'h1234_5678, 1));
        i_req1 = 0;

        // ---------------- randomized against burst-list model ----------------
        begin
            int unsigned     q[$];
            bit              holding, closed_by_last;
            logic [ACC_W-1:0] esum;
            bit              acc_x, out_x, pending;
            rst = 1; i_req = 0; i_last = 0; o_ack = 0; i_data = 0;
            tick();
            rst = 0; holding = 0; pending = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (!pending) begin
                    i_req  = ($urandom_range(0, 3) != 0);
                    i_data = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
                    i_last = ($urandom_range(0, 4) == 0);
                end
                o_ack = ($urandom_range(0, 2) != 0);
                rst   = ($urandom_range(0, 199) == 0);
                acc_x = i_req && !holding;
                out_x = holding && o_ack;
                tick();
                pending = i_req && !acc_x && !rst;
                if (rst) begin
                    q.delete(); holding = 0;
                end else begin
                    if (out_x) begin q.delete(); holding = 0; end
                    if (acc_x) begin
                        q.push_back(i_data);
                        closed_by_last = i_last;
                        if (q.size() == BLEN || closed_by_last) holding = 1;
                    end
                end
                esum = '0;
                foreach (q[k]) esum += ACC_W'(q[k]);
                check($sformatf("rand%0d", cyc), pack4(i_ack, o_req, o_sum, o_beats),
                      pack4(!holding, holding, esum, CNT_W'(q.size())));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
